dsp_arbiter_rr: RTL

Round-robin arbiter that shares one DSP48A1 slice among up to `NCLIENTS` ALU clients (IIR filter, oscillator, mixer ALUs). Each client drives its own packed DSP input bundle and holds a request for the whole length of its computation. The arbiter muxes the granted client's bundle onto the DSP and broadcasts the DSP outputs to all clients. Between owners it inserts a zero-opmode flush gap so one owner's accumulator never leaks into the next.

---
 rtl/dsp_arbiter_rr.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/dsp_arbiter_rr.sv
// Round-robin owner arbiter sharing one DSP48A1 slice, with a zero-input flush gap between owners.
// Optional ownership watchdog enabled by defining DSP_ARB_WATCHDOG_EN.
module dsp_arbiter_rr #(
  parameter  int unsigned NCLIENTS   = 4,
  parameter  int unsigned GAP_CYCLES = 2,
  parameter  int unsigned MAX_HOLD   = 64,
  localparam int unsigned DIN_W      = 44,
  localparam int unsigned DOUT_W     = 84
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NCLIENTS-1:0]       req,
  output logic [NCLIENTS-1:0]       grant,
  input  logic [NCLIENTS*DIN_W-1:0] clients_dsp_ins_flat,
  output logic [DOUT_W-1:0]         clients_dsp_outs_flat,
  output logic [DIN_W-1:0]          dsp_ins_flat,
  input  logic [DOUT_W-1:0]         dsp_outs_flat,
  output logic                      busy,
  output logic                      wdog_err
);

  localparam int unsigned PW = $clog2(NCLIENTS);
  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

  // Elaboration-time parameter range checks
  if (NCLIENTS < 2 || NCLIENTS > 8) begin : g_bad_nclients
    $error("dsp_arbiter_rr: NCLIENTS must be in 2..8");
  end
  if (GAP_CYCLES < 1 || GAP_CYCLES > 7) begin : g_bad_gap
    $error("dsp_arbiter_rr: GAP_CYCLES must be in 1..7");
  end
  if (MAX_HOLD < 1) begin : g_bad_hold
    $error("dsp_arbiter_rr: MAX_HOLD must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t              state, state_next;
  logic [NCLIENTS-1:0] grant_next;
  logic [NCLIENTS-1:0] eligible;
  logic [PW-1:0]       owner, owner_next;
  logic [PW-1:0]       ptr, ptr_next;
  logic [PW-1:0]       cand, pick_idx;
  logic                pick_valid;
  logic [GW-1:0]       gap_cnt, gap_next;
  logic                owner_req;
  logic                expire;

  assign owner_req = |(req & grant);

`ifdef DSP_ARB_WATCHDOG_EN
  localparam int unsigned HW = $clog2(MAX_HOLD + 1);

  logic [HW-1:0]       hold_cnt;
  logic [NCLIENTS-1:0] mask;

  assign expire   = (state == GRANT) && owner_req && (hold_cnt == HW'(MAX_HOLD - 1));
  assign eligible = req & ~mask;

  // Revoked owner stays masked until its request is observed low
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt <= '0;
      mask     <= '0;
      wdog_err <= 1'b0;
    end else begin
      hold_cnt <= (state == GRANT && state_next == GRANT) ? hold_cnt + HW'(1) : '0;
      mask     <= (mask & req) | (expire ? grant : '0);
      wdog_err <= expire;
    end
  end
`else
  assign expire   = 1'b0;
  assign eligible = req;
  assign wdog_err = 1'b0;
`endif

  // First eligible requester searching upward from ptr with wrap-around
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned k = 0; k < NCLIENTS; k++) begin
      cand = PW'((32'(ptr) + k) % NCLIENTS);
      if (!pick_valid && eligible[cand]) begin
        pick_valid = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    state_next = state;
    grant_next = grant;
    owner_next = owner;
    ptr_next   = ptr;
    gap_next   = gap_cnt;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          state_next = GRANT;
          grant_next = NCLIENTS'(1) << pick_idx;
          owner_next = pick_idx;
        end
      end
      GRANT: begin
        if (!owner_req || expire) begin
          state_next = GAP;
          grant_next = '0;
          ptr_next   = (owner == PW'(NCLIENTS - 1)) ? '0 : owner + PW'(1);
          gap_next   = GW'(GAP_CYCLES - 1);
        end
      end
      GAP: begin
        if (gap_cnt == '0) state_next = IDLE;
        else               gap_next   = gap_cnt - GW'(1);
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      grant   <= '0;
      owner   <= '0;
      ptr     <= '0;
      gap_cnt <= '0;
      busy    <= 1'b0;
    end else begin
      state   <= state_next;
      grant   <= grant_next;
      owner   <= owner_next;
      ptr     <= ptr_next;
      gap_cnt <= gap_next;
      busy    <= (state_next != IDLE);
    end
  end

  // Granted bundle passes straight through; zero whenever no grant is held
  always_comb begin
    dsp_ins_flat = '0;
    for (int unsigned i = 0; i < NCLIENTS; i++) begin
      if (grant[i]) dsp_ins_flat = clients_dsp_ins_flat[i*DIN_W +: DIN_W];
    end
  end

  assign clients_dsp_outs_flat = dsp_outs_flat;

endmodule
